// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for fetch_queue.
// The master drives the fetch side and decode ready; the slave is the queue itself.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_pc;
  logic [31:0]              in_instr;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_pc;
  logic [31:0]              out_instr;
  logic [31:0]              out_pc4;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_pc4, count
  );

  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_pc4, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode with flush support.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards a fetch straight to decode when empty.
module fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.slave  bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

  logic [31:0]      pc_mem_r    [DEPTH];
  logic [31:0]      instr_mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic             empty_s;
  logic             full_s;
  logic             in_ready_s;
  logic             bypass_s;
  logic             out_valid_s;
  logic             push_s;
  logic             pop_s;
  logic [31:0]      head_pc_s;
  logic [31:0]      head_instr_s;
  logic [31:0]      out_instr_s;

  // Handshake decode: flush blocks both sides, a bypassed-and-consumed fetch never touches storage.
  always_comb begin
    empty_s     = (count_r == {CNT_W{1'b0}});
    full_s      = (count_r == CNT_FULL);
    in_ready_s  = !full_s && !bus.flush;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_s    = empty_s && !bus.flush && bus.in_valid;
`else
    bypass_s    = 1'b0;
`endif
    out_valid_s = (!empty_s && !bus.flush) || bypass_s;
    pop_s       = out_valid_s && bus.out_ready && !bypass_s;
    push_s      = bus.in_valid && in_ready_s && !(bypass_s && bus.out_ready);
  end

  // Head selection; only the bypass build looks at the incoming fetch here.
  always_comb begin
`ifdef FETCH_QUEUE_BYPASS_EN
    if (bypass_s) begin
      head_pc_s    = bus.in_pc;
      head_instr_s = bus.in_instr;
    end else begin
      head_pc_s    = pc_mem_r[rd_ptr_r];
      head_instr_s = instr_mem_r[rd_ptr_r];
    end
`else
    head_pc_s    = pc_mem_r[rd_ptr_r];
    head_instr_s = instr_mem_r[rd_ptr_r];
`endif
    out_instr_s = out_valid_s ? head_instr_s : NOP_INSTR;
  end

  // Queue state: async reset clears storage, flush clears only the bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]    <= 32'h00000000;
        instr_mem_r[i] <= 32'h00000000;
      end
    end else if (bus.flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        pc_mem_r[wr_ptr_r]    <= bus.in_pc;
        instr_mem_r[wr_ptr_r] <= bus.in_instr;
        wr_ptr_r              <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_pc    = head_pc_s;
  assign bus.out_instr = out_instr_s;
  assign bus.out_pc4   = head_pc_s + 32'd4;
  assign bus.count     = count_r;
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of instruction entries; must be a power of two, at least 2.
REQ-002 Parameter NOP_INSTR, default 32'h00000000: value driven on out_instr while out_valid=0.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  fetch redirect (branch/jump/exception); discard all queued entries.
REQ-006 in_valid  input  1  fetch side presents a fetched instruction.
REQ-007 in_ready  output  1  queue accepts a push this cycle.
REQ-008 in_pc  input  32  PC of the fetched instruction, from the PC register output.
REQ-009 in_instr  input  32  instruction word read from instruction memory at in_pc.
REQ-010 out_valid  output  1  head entry available to decode.
REQ-011 out_ready  input  1  decode consumes the head entry this cycle (low = decode stall).
REQ-012 out_pc  output  32  PC of the head entry.
REQ-013 out_instr  output  32  instruction of the head entry; NOP_INSTR when out_valid=0.
REQ-014 out_pc4  output  32  out_pc + 32'd4, modulo 2^32.
REQ-015 count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.

Function
REQ-016 The queue is a circular buffer with read pointer, write pointer and count; both pointers wrap modulo DEPTH.
REQ-017 A push occurs when in_valid=1 and in_ready=1: {in_pc, in_instr} is written at the write pointer, and the write pointer advances by 1.
REQ-018 A pop occurs when out_valid=1 and out_ready=1: the read pointer advances by 1.
REQ-019 in_ready = (count < DEPTH) and not flush; when full, a push is refused even if a pop happens in the same cycle.
REQ-020 With a push and a pop in the same cycle, count is unchanged; a push alone adds 1; a pop alone subtracts 1.
REQ-021 out_valid = (count != 0) and not flush, except where REQ-031 applies.
REQ-022 Entries leave in push order (FIFO); no entry is duplicated or dropped except by flush.
REQ-023 flush has highest priority. In the flush cycle:
- any push is discarded;
- any pop is ignored;
- on the next edge, count, read pointer and write pointer become 0.
REQ-024 The cycle after flush, out_valid=0 unless a new push (or a bypass, REQ-031) occurs.
REQ-025 Decode stall (out_ready=0): the head outputs stay stable until popped.
REQ-026 Latency without bypass: an instruction pushed into an empty queue at edge N is presented with out_valid=1 in the cycle following edge N.
REQ-027 Sustained throughput is one push and one pop per cycle when 0 < count < DEPTH.

Reset
REQ-028 While rst=1:
- count=0, both pointers=0;
- all storage entries=0;
- out_valid=0, out_instr=NOP_INSTR;
- in_ready=1 (when flush=0).
REQ-029 Reset mid-operation discards all entries immediately and asynchronously.
REQ-030 The first push after rst deasserts is accepted on the next rising edge of clk.

Configuration
REQ-031 Macro FETCH_QUEUE_BYPASS_EN defined, when count=0, flush=0 and in_valid=1:
- out_valid=1, with out_pc/out_instr driven combinationally from in_pc/in_instr;
- if out_ready=1, the instruction is consumed directly: no write, and count stays 0;
- if out_ready=0, the instruction is pushed normally.
REQ-032 Macro FETCH_QUEUE_BYPASS_EN not defined: no combinational path exists from the in_* inputs to the out_* outputs, and the empty-queue latency is exactly one cycle (REQ-026).

Verification
REQ-033 Reset, then push in_pc=32'h00400000 with in_instr=32'h20080005 (out_ready=1): the next cycle shows out_valid=1, out_pc=32'h00400000, out_pc4=32'h00400004 and count returns to 0 after the pop; with bypass enabled, out_valid=1 in the push cycle itself.
REQ-034 Fill with out_ready=0 using PCs 0x00400000..0x0040000C: count=4, in_ready=0, and a fifth push (PC 0x00400010) is refused; pops then return the four PCs in order.
REQ-035 Stream 10 sequential PCs with in_valid=1 and out_ready=1 continuously: one output per cycle, in order, pointers wrapping past DEPTH with no loss.
REQ-036 With count=3, assert flush together with in_valid=1 (PC 0x00400100): the push is discarded, count=0 next cycle, out_valid=0 and out_instr=32'h00000000.
REQ-037 With count=2 and traffic in flight, assert rst asynchronously mid-cycle: out_valid and count drop to 0 before the next clock edge.
REQ-038 With count=2, push and pop in the same cycle: count stays 2 and the old head's successor is presented next.
